resp_mem_datos: RTL and testbench
=================================

# resp_mem_datos

Data-memory responder at the far end of the MEM-stage request interface of the pipelined MIPS core. It accepts the EX/MEM register's `MEM_RD`, `MEM_WR`, `w_h`, `DIR` and `DI` outputs and returns read data on `DO` to the MEM/WB register. A fixed, parameterized number of wait states models a slow memory; `STALL` freezes the pipeline until each access completes. Memory contents are word-organized with halfword write lanes.

## Interface
- `PROF`, 256: depth in 32-bit words; power of two, ≥4.
- `ESPERA`, 2: wait states per access; integer ≥1.
- `reloj` in 1: clock. All state changes on the rising edge.
- `resetM` in 1: reset. Synchronous and active-low.
- `MEM_RD` in 1: read request.
- `MEM_WR` in 1: write request. Has priority over `MEM_RD`.
- `w_h` in 1: access size. 1 = word, 0 = halfword.
- `DIR` in 32: byte address.
- `DI` in 32: write data. A halfword write uses `DI[15:0]`.
- `DO` out 32: read data. Registered.
- `STALL` out 1: pipeline hold request.
- `ERR_ALIN` out 1: misaligned-access flag, registered, one-cycle pulse.

## Operation
- The state machine has three states: REPOSO, ESP, RESP.
- In REPOSO, a request is `MEM_RD | MEM_WR`.
  - On a request, latch `MEM_WR`, `w_h`, `DIR` and `DI`; load `cnt <= ESPERA-1`; go to ESP.
  - With no request, stay in REPOSO.
- In ESP:
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, perform the access on the clock edge and go to RESP.
- In RESP, go to REPOSO unconditionally. Inputs are ignored in RESP, because the pipeline still presents the completed request during that cycle.
- `STALL = resetM & ((REPOSO & (MEM_RD|MEM_WR)) | ESP)`. It is combinational and is never high in RESP.
- Word index is `DIR[log2(PROF)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*PROF` bytes.
- Word read: `DO <= mem[idx]`.
- Halfword read: select the half with `DIR[1]` (0 = bits 15:0, 1 = bits 31:16), then sign-extend it to 32 bits.
- Word write: `mem[idx] <= DI`. `DO <= 0`.
- Halfword write: write `DI[15:0]` into the half selected by `DIR[1]` only; the other half is unchanged. `DO <= 0`.
- Alignment rules:
  - A word access requires `DIR[1:0]==0`.
  - A halfword access requires `DIR[0]==0`.
  - A misaligned access performs no write and sets `DO <= 0` and `ERR_ALIN <= 1`.
- `ERR_ALIN` is 1 only in the RESP cycle of a misaligned access; otherwise it is 0.
- `DO` holds its value outside access edges.
- Memory array contents are not affected by reset.

## Timing
- Reset (`resetM==0` at an edge):
  - state → REPOSO, `cnt` → 0, `DO` → 0, `ERR_ALIN` → 0.
  - `STALL` is 0 while `resetM` is low.
- A request seen in REPOSO at cycle 0:
  - `STALL` is high in cycles 0..ESPERA, i.e. ESPERA+1 cycles.
  - Cycle ESPERA+1 is RESP: `STALL` is 0 and `DO` / `ERR_ALIN` are valid. The pipeline advances at the end of that cycle.
- Back-to-back requests: the next request is seen in REPOSO at cycle ESPERA+2, so the throughput is one access per ESPERA+2 cycles.
- Simultaneous `MEM_RD` and `MEM_WR`: the request is treated as a write.
- Input changes during ESP have no effect, because the latched copies are used.
- Reset during ESP aborts the access: no write occurs and no RESP cycle follows.
- Reset asserted on the access edge itself wins; the write is not performed.

## Test plan
- **Word write then read.** `ESPERA=2`. WR word `DIR=0x10`, `DI=0xDEADBEEF`, then RD word `0x10`.
  - `STALL` is high for 3 cycles per access.
  - The RD's RESP cycle shows `DO=0xDEADBEEF`, `ERR_ALIN=0`.
- **Halfword lanes.** Preload `0x10` with `0x11223344`. WR half `DIR=0x12`, `DI=0x0000ABCD`, then RD word `0x10`.
  - Word read returns `0xABCD3344`.
  - RD half `0x12` returns `0xFFFFABCD`; RD half `0x10` returns `0x00003344`.
- **Misalignment.** Preload `0x10` with `0x11223344`.
  - WR word `DIR=0x12`: `ERR_ALIN=1` in RESP, `DO=0`, memory unchanged (`0x11223344`).
  - RD half `0x11`: `ERR_ALIN=1`, `DO=0`.
- **Wrap and priority.** `PROF=256`. WR word `DIR=0x400`, `DI=0x5`, with `MEM_RD=1` also asserted.
  - Treated as a write; RESP `DO=0`.
  - A following RD word `0x0` returns `0x5`.
- **Reset mid-access.** Start WR word `0x20`, `DI=0x77`; pull `resetM` low in the first ESP cycle.
  - `STALL=0`, `DO=0` after the edge.
  - A later RD word `0x20` returns the prior contents, not `0x77`.
- **Back-to-back and idle.** Hold `MEM_RD` high continuously with `ESPERA=1`.
  - `STALL` pattern repeats 1,1,0 and `DO` updates every 3rd cycle.
  - With no requests, `STALL` stays 0 and `DO` holds.

Source files
------------

// File: rtl/resp_mem_datos.sv
// resp_mem_datos -- data-memory responder for the MEM stage of the pipelined MIPS core.
//
// The memory is organized in 32-bit words, and each word has two 16-bit write lanes.
// Every access takes a fixed number of wait states (ESPERA). STALL holds the pipeline
// until the response cycle (RESP). In RESP, DO and ERR_ALIN are valid.
//
// Handshake: the pipeline presents a request (MEM_RD | MEM_WR) and keeps it stable
// while STALL is high. STALL drops in the RESP cycle, and the pipeline advances at the
// end of that cycle. Request inputs are sampled only in REPOSO. A new request can
// therefore be seen ESPERA+2 cycles after the previous one.
//
// Ports:
//   reloj     in   clock, rising edge
//   resetM    in   synchronous active-low reset (memory array contents are kept)
//   MEM_RD    in   read request
//   MEM_WR    in   write request, has priority over MEM_RD
//   w_h       in   access size: 1 = word, 0 = halfword
//   DIR[31:0] in   byte address (wraps modulo 4*PROF)
//   DI[31:0]  in   write data (halfword writes use DI[15:0])
//   DO[31:0]  out  registered read data, 0 after writes and misaligned accesses
//   STALL     out  combinational pipeline hold request
//   ERR_ALIN  out  registered misalignment pulse, high only in RESP
//   o_estado  out  debug view of the FSM state (0 REPOSO, 1 ESP, 2 RESP)
module resp_mem_datos #(
    parameter int PROF   = 256,
    parameter int ESPERA = 2
) (
    input  logic        reloj,
    input  logic        resetM,
    input  logic        MEM_RD,
    input  logic        MEM_WR,
    input  logic        w_h,
    input  logic [31:0] DIR,
    input  logic [31:0] DI,
    output logic [31:0] DO,
    output logic        STALL,
    output logic        ERR_ALIN,
    output logic [1:0]  o_estado
);

    localparam int AW = $clog2(PROF);
    localparam int CW = (ESPERA > 1) ? $clog2(ESPERA) : 1;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        ESP    = 2'd1,
        RESP   = 2'd2
    } estado_t;

    estado_t        r_estado;
    logic [CW-1:0]  r_cnt;
    logic           r_wr;
    logic           r_wh;
    logic [AW+1:0]  r_dir;
    logic [31:0]    r_di;
    logic [31:0]    r_mem [PROF];

    logic           w_req;
    logic           w_acc;
    logic           w_mal;
    logic           w_we;
    logic           w_we_lo;
    logic           w_we_hi;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_wdata;
    logic [31:0]    w_rword;
    logic [15:0]    w_rhalf;
    logic [31:0]    w_rdata;
    logic           w_unused_dir;

    // Upper address bits are ignored; the address wraps.
    assign w_unused_dir = ^DIR[31:AW+2];

    assign w_req   = MEM_RD | MEM_WR;
    // The access edge is the last ESP cycle.
    assign w_acc   = (r_estado == ESP) && (r_cnt == '0);
    assign w_idx   = r_dir[AW+1:2];
    assign w_mal   = r_wh ? (r_dir[1:0] != 2'b00) : r_dir[0];

    // Reset on the access edge wins, so resetM gates the write enable.
    assign w_we    = resetM & w_acc & r_wr & ~w_mal;
    assign w_we_lo = w_we & (r_wh | ~r_dir[1]);
    assign w_we_hi = w_we & (r_wh |  r_dir[1]);
    // A halfword write replicates DI[15:0] into both lanes.
    // The lane enables then pick the half that is actually written.
    assign w_wdata = r_wh ? r_di : {r_di[15:0], r_di[15:0]};

    assign w_rword = r_mem[w_idx];
    assign w_rhalf = r_dir[1] ? w_rword[31:16] : w_rword[15:0];
    assign w_rdata = r_wh ? w_rword : {{16{w_rhalf[15]}}, w_rhalf};

    assign STALL    = resetM & (((r_estado == REPOSO) & w_req) | (r_estado == ESP));
    assign o_estado = r_estado;

    always_ff @(posedge reloj) begin
        if (!resetM) begin
            r_estado <= REPOSO;
            r_cnt    <= '0;
            DO       <= '0;
            ERR_ALIN <= 1'b0;
        end else begin
            ERR_ALIN <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (w_req) begin
                        r_wr     <= MEM_WR;
                        r_wh     <= w_h;
                        r_dir    <= DIR[AW+1:0];
                        r_di     <= DI;
                        r_cnt    <= CW'(ESPERA - 1);
                        r_estado <= ESP;
                    end
                end
                ESP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_estado <= RESP;
                        ERR_ALIN <= w_mal;
                        DO       <= (w_mal || r_wr) ? 32'h0 : w_rdata;
                    end
                end
                RESP: begin
                    r_estado <= REPOSO;
                end
                default: begin
                    r_estado <= REPOSO;
                end
            endcase
        end
    end

    // The memory array has no reset.
    always_ff @(posedge reloj) begin
        if (w_we_lo) r_mem[w_idx][15:0]  <= w_wdata[15:0];
        if (w_we_hi) r_mem[w_idx][31:16] <= w_wdata[31:16];
    end

endmodule

// File: tb/tb_resp_mem_datos.sv
module tb_resp_mem_datos;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT a: ESPERA=2, PROF=256
  logic        a_rd = 0, a_wr = 0, a_wh = 0;
  logic [31:0] a_dir = 0, a_di = 0;
  logic [31:0] a_do;
  logic        a_stall, a_err;
  logic [1:0]  a_st;

  // DUT b: ESPERA=1, PROF=16
  logic        b_rd = 0, b_wr = 0, b_wh = 0;
  logic [31:0] b_dir = 0, b_di = 0;
  logic [31:0] b_do;
  logic        b_stall, b_err;
  logic [1:0]  b_st;

  resp_mem_datos #(.PROF(256), .ESPERA(2)) dut_a (
    .reloj(clk), .resetM(rst_n), .MEM_RD(a_rd), .MEM_WR(a_wr), .w_h(a_wh),
    .DIR(a_dir), .DI(a_di), .DO(a_do), .STALL(a_stall), .ERR_ALIN(a_err),
    .o_estado(a_st)
  );

  resp_mem_datos #(.PROF(16), .ESPERA(1)) dut_b (
    .reloj(clk), .resetM(rst_n), .MEM_RD(b_rd), .MEM_WR(b_wr), .w_h(b_wh),
    .DIR(b_dir), .DI(b_di), .DO(b_do), .STALL(b_stall), .ERR_ALIN(b_err),
    .o_estado(b_st)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit cur_stall(input bit sel);
    return sel ? b_stall : a_stall;
  endfunction

  // Driver: call at a negedge with the selected DUT in REPOSO.
  // Returns at a negedge with the DUT back in REPOSO and the inputs idle.
  task automatic access(input bit sel, input logic rd, input logic wr, input logic wh,
                        input logic [31:0] dir, input logic [31:0] di,
                        output logic [31:0] do_o, output logic err_o, output int nstall);
    if (sel) begin b_rd = rd; b_wr = wr; b_wh = wh; b_dir = dir; b_di = di; end
    else     begin a_rd = rd; a_wr = wr; a_wh = wh; a_dir = dir; a_di = di; end
    nstall = 0;
    #1;
    while (cur_stall(sel) && nstall < 20) begin
      nstall++;
      @(negedge clk);
    end
    do_o  = sel ? b_do : a_do;
    err_o = sel ? b_err : a_err;
    if (sel) begin b_rd = 0; b_wr = 0; end
    else     begin a_rd = 0; a_wr = 0; end
    @(negedge clk);
  endtask

  logic [31:0] d;
  logic        e;
  int          ns;
  logic [31:0] exp_do_b [9] = '{32'h0, 32'h0, 32'h0BADCAFE, 32'h0BADCAFE, 32'h0BADCAFE,
                                32'h13579BDF, 32'h13579BDF, 32'h13579BDF, 32'h0BADCAFE};

  initial begin
    // ---- reset, with a request pending to show STALL is masked
    a_rd = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, a_stall}, 32'h0);
    chk("rst_do", a_do, 32'h0);
    chk("rst_err", {31'b0, a_err}, 32'h0);
    chk("rst_state", {30'b0, a_st}, 32'h0);
    a_rd = 0;
    rst_n = 1;
    @(negedge clk);

    // ---- word write then read
    access(0, 0, 1, 1, 32'h10, 32'hDEADBEEF, d, e, ns);
    chk("ww_stall", ns, 3);
    chk("ww_do", d, 32'h0);
    access(0, 1, 0, 1, 32'h10, 32'h0, d, e, ns);
    chk("wr_stall", ns, 3);
    chk("wr_do", d, 32'hDEADBEEF);
    chk("wr_err", {31'b0, e}, 32'h0);
    chk("wr_state_after", {30'b0, a_st}, 32'h0);

    // ---- halfword lanes
    access(0, 0, 1, 1, 32'h10, 32'h11223344, d, e, ns);
    access(0, 0, 1, 0, 32'h12, 32'h0000ABCD, d, e, ns);
    chk("hw_do", d, 32'h0);
    access(0, 1, 0, 1, 32'h10, 32'h0, d, e, ns);
    chk("hw_word", d, 32'hABCD3344);
    access(0, 1, 0, 0, 32'h12, 32'h0, d, e, ns);
    chk("hr_hi_sext", d, 32'hFFFFABCD);
    access(0, 1, 0, 0, 32'h10, 32'h0, d, e, ns);
    chk("hr_lo", d, 32'h00003344);

    // ---- misalignment
    access(0, 0, 1, 1, 32'h10, 32'h11223344, d, e, ns);
    access(0, 1, 0, 1, 32'h10, 32'h0, d, e, ns);
    chk("mis_pre", d, 32'h11223344);
    access(0, 0, 1, 1, 32'h12, 32'hFFFFFFFF, d, e, ns);
    chk("mis_ww_err", {31'b0, e}, 32'h1);
    chk("mis_ww_do", d, 32'h0);
    chk("mis_err_pulse", {31'b0, a_err}, 32'h0);
    access(0, 1, 0, 1, 32'h10, 32'h0, d, e, ns);
    chk("mis_mem_kept", d, 32'h11223344);
    access(0, 1, 0, 0, 32'h11, 32'h0, d, e, ns);
    chk("mis_rh_err", {31'b0, e}, 32'h1);
    chk("mis_rh_do", d, 32'h0);

    // ---- wrap and write priority (a read first so DO is nonzero)
    access(0, 1, 0, 1, 32'h10, 32'h0, d, e, ns);
    access(0, 1, 1, 1, 32'h400, 32'h5, d, e, ns);
    chk("prio_do", d, 32'h0);
    chk("prio_err", {31'b0, e}, 32'h0);
    access(0, 1, 0, 1, 32'h0, 32'h0, d, e, ns);
    chk("wrap_rd", d, 32'h5);

    // ---- reset in first ESP cycle aborts the write
    access(0, 0, 1, 1, 32'h20, 32'h12345678, d, e, ns);
    access(0, 1, 0, 1, 32'h20, 32'h0, d, e, ns);
    chk("rm_pre", d, 32'h12345678);
    a_wr = 1; a_wh = 1; a_dir = 32'h20; a_di = 32'h77;
    #1;
    chk("rm_stall0", {31'b0, a_stall}, 32'h1);
    @(negedge clk);
    chk("rm_in_esp", {30'b0, a_st}, 32'h1);
    rst_n = 0; a_wr = 0;
    #1;
    chk("rm_stall_lowrst", {31'b0, a_stall}, 32'h0);
    @(negedge clk);
    chk("rm_stall", {31'b0, a_stall}, 32'h0);
    chk("rm_do", a_do, 32'h0);
    chk("rm_state", {30'b0, a_st}, 32'h0);
    rst_n = 1;
    @(negedge clk);
    access(0, 1, 0, 1, 32'h20, 32'h0, d, e, ns);
    chk("rm_mem_kept", d, 32'h12345678);

    // ---- reset on the access edge itself
    access(0, 0, 1, 1, 32'h24, 32'hCAFEF00D, d, e, ns);
    a_wr = 1; a_wh = 1; a_dir = 32'h24; a_di = 32'h1;
    @(negedge clk);
    @(negedge clk);
    chk("ra_last_esp", {30'b0, a_st}, 32'h1);
    rst_n = 0; a_wr = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ra_no_resp", {30'b0, a_st}, 32'h0);
    access(0, 1, 0, 1, 32'h24, 32'h0, d, e, ns);
    chk("ra_mem_kept", d, 32'hCAFEF00D);

    // ---- back-to-back reads on ESPERA=1, then idle
    access(1, 0, 1, 1, 32'h8, 32'h0BADCAFE, d, e, ns);
    chk("b_ww_stall", ns, 2);
    access(1, 0, 1, 1, 32'hC, 32'h13579BDF, d, e, ns);
    b_rd = 1; b_wh = 1; b_dir = 32'h8;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk($sformatf("b2b_stall_%0d", k), {31'b0, b_stall}, (k % 3 == 2) ? 32'h0 : 32'h1);
      chk($sformatf("b2b_do_%0d", k), b_do, exp_do_b[k]);
      // DIR changes during RESP are ignored by the responder
      if (k == 2) b_dir = 32'hC;
      if (k == 5) b_dir = 32'h8;
      if (k == 8) b_rd = 0;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("idle_stall_%0d", k), {31'b0, b_stall}, 32'h0);
      chk($sformatf("idle_do_%0d", k), b_do, 32'h0BADCAFE);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
